// File: rtl/fetch_stage_if.sv
// Instruction memory bus between fetch and imem.
// Fetch drives the address, imem answers combinationally.
interface fetch_stage_if;
  logic [31:0] imemAddr;
  logic [31:0] imemData;

  modport master (
    output imemAddr,
    input  imemData
  );

  modport slave (
    input  imemAddr,
    output imemData
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect mux, IF/ID reg.
// FETCH_STALL_CNT_EN adds saturating stall/flush event counters.
module fetch_stage (
  input  logic                clk,
  input  logic                rstN,
  input  logic                stall,
  input  logic                pcSrc,
  input  logic [31:0]         branchTarget,
  input  logic                jump,
  input  logic [25:0]         jumpIndex,
  fetch_stage_if.master       imem,
  output logic [31:0]         ifidInstr,
  output logic [31:0]         ifidPcPlus4,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]         stallCount,
  output logic [15:0]         flushCount,
`endif
  output logic                ifidValid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        redirect;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc4_q[31:28], jumpIndex, 2'b00};
  assign redirect    = pcSrc | jump;

  // Next PC: branch beats jump beats stall beats sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (pcSrc)      pc_d = branchTarget;
    else if (jump)  pc_d = jump_target;
    else if (stall) pc_d = pc_q;
  end

  // IF/ID: flush on redirect, hold on stall, else capture fetch.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem.imemData;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imemAddr = pc_q;
  assign ifidInstr     = instr_q;
  assign ifidPcPlus4   = pc4_q;
  assign ifidValid     = valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a redirect never counts as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !redirect && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (redirect && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic
// checked against a rule-level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rstN;
  logic        stall;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        jump;
  logic [25:0] jumpIndex;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stallCount;
  logic [15:0] flushCount;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stalls, m_flushes;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk          (clk),
    .rstN         (rstN),
    .stall        (stall),
    .pcSrc        (pcSrc),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpIndex    (jumpIndex),
    .imem         (imem.master),
    .ifidInstr    (ifidInstr),
    .ifidPcPlus4  (ifidPcPlus4),
`ifdef FETCH_STALL_CNT_EN
    .stallCount   (stallCount),
    .flushCount   (flushCount),
`endif
    .ifidValid    (ifidValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign imem.imemData = imem_word(imem.imemAddr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  imem.imemAddr, m_pc);
    chk({tag, ".instr"}, ifidInstr, m_instr);
    chk({tag, ".pc4"},   ifidPcPlus4, m_pc4);
    chk({tag, ".valid"}, {31'h0, ifidValid}, {31'h0, m_valid});
`ifdef FETCH_STALL_CNT_EN
    chk({tag, ".scnt"}, {16'h0, stallCount}, m_stalls);
    chk({tag, ".fcnt"}, {16'h0, flushCount}, m_flushes);
`endif
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // One clock edge with the given inputs; model follows the rules.
  task automatic step(input logic s, input logic p,
                      input logic [31:0] bt, input logic j,
                      input logic [25:0] ji);
    logic [31:0] npc;
    stall = s; pcSrc = p; branchTarget = bt;
    jump = j; jumpIndex = ji;
    if (p)      npc = bt;
    else if (j) npc = (m_pc4 & 32'hF000_0000) + ({6'h0, ji} * 4);
    else if (s) npc = m_pc;
    else        npc = m_pc + 32'd4;
    if (p || j) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (m_flushes < 65535) m_flushes++;
    end else if (!s) begin
      m_instr = imem_word(m_pc);
      m_pc4 = m_pc + 32'd4;
      m_valid = 1;
    end else if (m_stalls < 65535) begin
      m_stalls++;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'hDEAD_BEEF, 0, 26'h3FF_FFFF);
  endtask

  initial begin
    stall = 0; pcSrc = 0; branchTarget = 0;
    jump = 0; jumpIndex = 0;
    rstN = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rstN = 1;
    @(posedge clk); #1;
    m_instr = 32'h2008_0005; m_pc4 = 4; m_valid = 1; m_pc = 4;
    chk("seq.addr1", imem.imemAddr, 32'h4);
    chk("seq.instr1", ifidInstr, 32'h2008_0005);
    chk("seq.pc4_1", ifidPcPlus4, 32'h4);
    chk("seq.valid1", {31'h0, ifidValid}, 32'h1);
    idle();
    chk("seq.addr2", imem.imemAddr, 32'h8);
    check_all("seq2");

    step(1, 0, 32'h0, 0, 26'h0);
    step(1, 0, 32'h0, 0, 26'h0);
    chk("stall.addr", imem.imemAddr, 32'h8);
    check_all("stall");
    idle();
    chk("post_stall.addr", imem.imemAddr, 32'hC);

    step(0, 1, 32'h40, 0, 26'h0);
    chk("br.addr", imem.imemAddr, 32'h40);
    check_all("br");
    idle();
    chk("br.fetch", ifidPcPlus4, 32'h44);
    check_all("br_next");

    step(0, 1, 32'h1000_000C, 0, 26'h0);
    idle();
    chk("jmp.setup", ifidPcPlus4, 32'h1000_0010);
    step(0, 0, 32'hFFFF_0000, 1, 26'h000_0100);
    chk("jmp.addr", imem.imemAddr, 32'h1000_0400);
    check_all("jmp");
    step(0, 1, 32'h80, 1, 26'h2AA_AAAA);
    chk("br_jmp.addr", imem.imemAddr, 32'h80);
    step(0, 1, 32'h83, 0, 26'h0);
    chk("unaligned", imem.imemAddr, 32'h83);

    step(0, 1, 32'hFFFF_FFFC, 0, 26'h0);
    idle();
    chk("wrap.addr", imem.imemAddr, 32'h0);
    chk("wrap.pc4", ifidPcPlus4, 32'h0);
    check_all("wrap");
    step(1, 1, 32'h20, 0, 26'h0);
    chk("prec.addr", imem.imemAddr, 32'h20);
    check_all("prec");
    idle();
    chk("pre_arst.addr", imem.imemAddr, 32'h24);

    @(negedge clk);
    stall = 1; pcSrc = 1; branchTarget = 32'h100;
    rstN = 0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rstN = 1;
    stall = 0; pcSrc = 0;
    #1;
    idle();
    chk("arst_rel.addr", imem.imemAddr, 32'h4);
    check_all("arst_rel");

    for (int i = 0; i < 400; i++) begin
      logic rs, rp, rj;
      rs = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 7) == 0);
      rj = ($urandom_range(0, 9) == 0);
      step(rs, rp, $urandom, rj, 26'($urandom));
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetchStage

Interface
REQ-001 SHALL provide port: clk  input  1  single clock, all state rising-edge.
REQ-002 SHALL provide port: rstN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-004 SHALL provide port: pcSrc  input  1  taken-branch redirect from decode (bne resolved).
REQ-005 SHALL provide port: branchTarget  input  32  redirect address, valid when pcSrc=1.
REQ-006 SHALL provide port: jump  input  1  jump redirect from decode.
REQ-007 SHALL provide port: jumpIndex  input  26  jump instruction index field.
REQ-008 SHALL provide port: imemData  input  32  instruction word returned combinationally for imemAddr.
REQ-009 SHALL provide port: imemAddr  output  32  current PC to instruction memory.
REQ-010 SHALL provide port: ifidInstr  output  32  registered instruction to decode/control logic.
REQ-011 SHALL provide port: ifidPcPlus4  output  32  registered PC+4 of ifidInstr.
REQ-012 SHALL provide port: ifidValid  output  1  ifidInstr is a real fetched instruction, not a bubble.
REQ-013 SHALL provide ports (only with FETCH_STALL_CNT_EN): stallCount  output  16, flushCount  output  16.

Function
REQ-014 SHALL drive imemAddr directly from the PC register, zero combinational logic on the path.
REQ-015 SHALL select next PC by fixed priority: pcSrc -> branchTarget; else jump -> {ifidPcPlus4[31:28], jumpIndex, 2'b00}; else stall -> hold; else PC+4.
REQ-016 SHALL compute PC+4 modulo 2^32; PC 0xFFFFFFFC advances to 0x00000000 without flag.
REQ-017 SHALL, on an edge with no redirect and no stall, load ifidInstr<=imemData, ifidPcPlus4<=PC+4, ifidValid<=1; fetch-to-decode latency one cycle.
REQ-018 SHALL, on an edge with pcSrc or jump asserted, flush IF/ID: ifidInstr<=0x00000000 (nop), ifidPcPlus4<=0, ifidValid<=0.
REQ-019 SHALL give redirect precedence over stall: pcSrc/jump with stall=1 still redirects PC and flushes IF/ID.
REQ-020 SHALL, on stall without redirect, hold PC, ifidInstr, ifidPcPlus4, ifidValid unchanged.
REQ-021 SHALL ignore branchTarget and jumpIndex when the respective select is 0; pcSrc and jump together follow pcSrc only.
REQ-022 SHALL not check PC alignment; low two bits of branchTarget pass through unchanged.

Reset
REQ-023 SHALL, while rstN=0, asynchronously force PC=0x00000000, ifidInstr=0, ifidPcPlus4=0, ifidValid=0, counters=0.
REQ-024 SHALL, on rstN deassertion, fetch from 0x00000000 at the first rising edge; reset mid-stall or mid-redirect discards the pending action.

Configuration
REQ-025 SHALL, with FETCH_STALL_CNT_EN defined, implement stallCount (+1 per edge with stall=1 and no redirect) and flushCount (+1 per edge with pcSrc or jump), both saturating at 0xFFFF.
REQ-026 SHALL, without FETCH_STALL_CNT_EN, omit both counter ports and all counter logic; remaining behaviour identical.

Verification
REQ-027 SHALL test reset/sequential: release rstN, imem returns 0x20080005 at 0x0 -> imemAddr 0,4,8; after edge 1 ifidInstr=0x20080005, ifidPcPlus4=4, ifidValid=1.
REQ-028 SHALL test stall: stall=1 for 2 cycles at PC=0x8 -> imemAddr stays 0x8, IF/ID unchanged; stallCount=2 (macro on).
REQ-029 SHALL test branch: pcSrc=1, branchTarget=0x40 at PC=0xC -> next imemAddr=0x40, ifidInstr=0, ifidValid=0; next cycle fetches 0x40.
REQ-030 SHALL test jump: ifidPcPlus4=0x10000010, jump=1, jumpIndex=0x0000100 -> next PC=0x10000400; pcSrc+jump together with branchTarget=0x80 -> PC=0x80.
REQ-031 SHALL test wrap/precedence: PC=0xFFFFFFFC -> next PC 0x0; stall=1 with pcSrc=1 -> redirect taken, flushCount increments, stallCount does not.
REQ-032 SHALL test async reset: rstN low mid-cycle at PC=0x24 -> PC and IF/ID clear immediately without clock edge.
